// File: rtl/fc_neuron_scheduler.sv
// Fully-connected neuron scheduler: buffers one input vector, then streams it
// against external weight memory one MAC per cycle, emitting ReLU'd results per neuron.
module fc_neuron_scheduler #(
    parameter int WIDTH = 8,
    parameter int IN    = 128,
    parameter int OUT   = 10,
    localparam int ACC_W = WIDTH * 2 + $clog2(IN),
    localparam int WA_W  = $clog2(IN * OUT)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        in_data,
    output logic [WA_W-1:0]         w_addr,
    input  logic [WIDTH-1:0]        w_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ACC_W-1:0]        out_data,
    output logic [$clog2(OUT)-1:0]  out_idx,
    output logic                    busy,
    output logic                    done
);

    localparam int KW = (IN > 1) ? $clog2(IN) : 1;
    localparam int IW = $clog2(OUT);

    typedef enum logic [1:0] {
        LOAD,
        COMPUTE,
        FLUSH,
        EMIT
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0]        buffer [IN];
    logic [KW-1:0]           cnt;
    logic [KW-1:0]           k;
    logic [IW-1:0]           n;
    logic signed [ACC_W-1:0] acc;
    logic [WIDTH-1:0]        data_q;
    logic                    mac_en;

    logic                    last_k;
    logic                    last_cnt;
    logic                    last_n;
    logic [WA_W-1:0]         addr;
    logic signed [2*WIDTH-1:0] prod;
    logic signed [ACC_W-1:0]   prod_ext;

    assign last_k   = (k == KW'(IN - 1));
    assign last_cnt = (cnt == KW'(IN - 1));
    assign last_n   = (n == IW'(OUT - 1));
    assign addr     = WA_W'(n) * WA_W'(IN) + WA_W'(k);
    assign prod     = $signed(data_q) * $signed(w_data);
    assign prod_ext = ACC_W'(prod);

    always_ff @(posedge clk) begin
        if (rst) state <= LOAD;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        w_addr     = '0;
        out_data   = '0;
        out_idx    = '0;
        done       = 1'b0;
        busy       = !((state == LOAD) && (cnt == '0));
        case (state)
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid && last_cnt) state_next = COMPUTE;
            end
            COMPUTE: begin
                w_addr = addr;
                if (last_k) state_next = FLUSH;
            end
            FLUSH: state_next = EMIT;
            EMIT: begin
                out_valid = 1'b1;
                out_data  = acc[ACC_W-1] ? '0 : acc;
                out_idx   = n;
                if (out_ready) begin
                    if (last_n) begin
                        done       = 1'b1;
                        state_next = LOAD;
                    end else begin
                        state_next = COMPUTE;
                    end
                end
            end
            default: state_next = LOAD;
        endcase
    end

    // Buffer is not reset; cnt restarting at 0 guarantees a partial vector is overwritten.
    always_ff @(posedge clk) begin
        if (!rst && state == LOAD && in_valid)
            buffer[cnt] <= in_data;
    end

    // w_data arrives one cycle after its address, so the MAC lags COMPUTE by one cycle
    // and the last product lands during FLUSH.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            k      <= '0;
            n      <= '0;
            acc    <= '0;
            data_q <= '0;
            mac_en <= 1'b0;
        end else begin
            mac_en <= (state == COMPUTE);
            if (mac_en) acc <= acc + prod_ext;
            case (state)
                LOAD: begin
                    if (in_valid) begin
                        if (last_cnt) begin
                            cnt <= '0;
                            n   <= '0;
                            k   <= '0;
                            acc <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                COMPUTE: begin
                    data_q <= buffer[k];
                    k      <= last_k ? '0 : k + 1'b1;
                end
                EMIT: begin
                    if (out_ready && !last_n) begin
                        n   <= n + 1'b1;
                        acc <= '0;
                        k   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fc_neuron_scheduler.sv
// Bench for fc_neuron_scheduler: dot-product/ReLU reference model with a per-cycle
// compare process, plus literal checks on directed vectors.
module tb_fc_neuron_scheduler;

    localparam int WIDTH = 8;
    localparam int IN    = 128;
    localparam int OUT   = 10;
    localparam int ACC_W = WIDTH * 2 + $clog2(IN);
    localparam int WA_W  = $clog2(IN * OUT);
    localparam int IW    = $clog2(OUT);

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [WA_W-1:0]  w_addr;
    logic [WIDTH-1:0] w_data;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_data;
    logic [IW-1:0]    out_idx;
    logic             busy;
    logic             done;

    fc_neuron_scheduler #(.WIDTH(WIDTH), .IN(IN), .OUT(OUT)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .w_addr(w_addr), .w_data(w_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_idx(out_idx),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int wmem [IN*OUT];
    int vec  [IN];
    always @(posedge clk) w_data <= WIDTH'(wmem[w_addr]);

    int compared   = 0;
    int mismatched = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model state
    int     xv [IN];
    int     beats = 0;
    int     exp_data[$];
    int     exp_idx[$];
    int     got_data[$];
    int     got_idx[$];
    int     done_cnt = 0;
    longint cyc = 0;
    longint exp_first = 0;
    bit     first_pending = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        int s;
        if (!rst) begin
            chk("in_ready", in_ready, exp_data.size() == 0);
            if (in_ready) chk("w_addr_load", w_addr, 0);
            if (in_valid && in_ready) begin
                xv[beats] = int'($signed(in_data));
                beats++;
                if (beats == IN) begin
                    beats = 0;
                    for (int n = 0; n < OUT; n++) begin
                        s = 0;
                        for (int k = 0; k < IN; k++) s += xv[k] * wmem[n*IN + k];
                        exp_data.push_back(s < 0 ? 0 : s);
                        exp_idx.push_back(n);
                    end
                    first_pending = 1;
                    exp_first = cyc + IN + 2;
                end
            end
            if (out_valid) begin
                if (exp_data.size() == 0) begin
                    chk("spurious_out_valid", out_valid, 0);
                end else begin
                    chk("out_data", out_data, exp_data[0]);
                    chk("out_idx", out_idx, exp_idx[0]);
                    chk("w_addr_emit", w_addr, 0);
                    if (first_pending && exp_idx[0] == 0) begin
                        chk("first_latency", cyc, exp_first);
                        first_pending = 0;
                    end
                    if (out_ready) begin
                        chk("done_on_accept", done, exp_idx[0] == OUT - 1);
                        if (done) done_cnt++;
                        got_data.push_back(int'(out_data));
                        got_idx.push_back(int'(out_idx));
                        void'(exp_data.pop_front());
                        void'(exp_idx.pop_front());
                    end else begin
                        chk("done_stalled", done, 0);
                    end
                end
            end else begin
                chk("done_idle", done, 0);
            end
        end
    end

    task automatic send_vector(input bit rand_valid);
        int t;
        for (int i = 0; i < IN; i++) begin
            if (rand_valid) begin
                while ($urandom_range(0, 2) == 0) begin
                    in_valid = 1'b0;
                    @(posedge clk); #1;
                end
            end
            in_valid = 1'b1;
            in_data  = WIDTH'(vec[i]);
            t = 0;
            while (!in_ready && t < 20000) begin
                @(posedge clk); #1;
                t++;
            end
            if (t >= 20000) chk("in_ready_timeout", 0, 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int t = 0;
        while (done_cnt < target && t < 20000) begin
            @(posedge clk); #1;
            t++;
        end
        chk("done_count", done_cnt, target);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_data.delete();
        exp_idx.delete();
        beats = 0;
        first_pending = 0;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_idx", out_idx, 0);
        chk("rst_w_addr", w_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst = 1'b0;
    endtask

    task automatic fill(input int x, input int w);
        for (int i = 0; i < IN; i++) vec[i] = x;
        for (int i = 0; i < IN*OUT; i++) wmem[i] = w;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int t;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        fill(0, 0);
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // All ones; junk in_valid during COMPUTE must be ignored
        fill(1, 1);
        got_data.delete(); got_idx.delete();
        send_vector(0);
        in_valid = 1'b1; in_data = 8'h5a;
        t = 0;
        while (!out_valid && t < 1000) begin @(posedge clk); #1; t++; end
        in_valid = 1'b0;
        wait_done(1);
        chk("ones_count", got_data.size(), OUT);
        for (int i = 0; i < OUT; i++) begin
            chk("ones_data", got_data[i], 128);
            chk("ones_idx", got_idx[i], i);
        end

        // Most negative operands: maximum positive accumulation
        fill(-128, -128);
        got_data.delete(); got_idx.delete();
        send_vector(0);
        wait_done(2);
        for (int i = 0; i < OUT; i++) chk("maxneg_data", got_data[i], 2097152);

        // Neuron 3 negative, neuron 7 sums to exactly zero; stall 20 cycles in EMIT
        fill(1, 1);
        for (int k = 0; k < IN; k++) wmem[3*IN + k] = -1;
        for (int k = 0; k < IN; k++) wmem[7*IN + k] = (k % 2 == 0) ? 1 : -1;
        got_data.delete(); got_idx.delete();
        out_ready = 1'b0;
        send_vector(0);
        t = 0;
        while (!out_valid && t < 1000) begin @(posedge clk); #1; t++; end
        chk("stall_reached_emit", out_valid, 1);
        repeat (20) @(posedge clk);
        #1;
        chk("stall_idx", out_idx, 0);
        out_ready = 1'b1;
        wait_done(3);
        for (int i = 0; i < OUT; i++)
            chk("relu_data", got_data[i], (i == 3 || i == 7) ? 0 : 128);

        // Reset mid-COMPUTE (neuron 2, k=60), partial load, then a fresh vector
        for (int i = 0; i < IN; i++) vec[i] = $urandom_range(0, 255) - 128;
        for (int i = 0; i < IN*OUT; i++) wmem[i] = $urandom_range(0, 255) - 128;
        send_vector(0);
        t = 0;
        while (w_addr != WA_W'(2*IN + 60) && t < 5000) begin @(posedge clk); #1; t++; end
        chk("reach_k60", w_addr, 2*IN + 60);
        do_reset();
        base = done_cnt;
        in_valid = 1'b1; in_data = 8'd7;
        repeat (50) @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("partial_busy", busy, 1);
        do_reset();
        for (int i = 0; i < IN; i++) vec[i] = $urandom_range(0, 255) - 128;
        got_data.delete(); got_idx.delete();
        send_vector(0);
        wait_done(base + 1);
        chk("post_rst_first_idx", got_idx[0], 0);

        // Random in_valid gaps, two vectors back to back
        base = done_cnt;
        for (int i = 0; i < IN; i++) vec[i] = $urandom_range(0, 255) - 128;
        send_vector(1);
        for (int i = 0; i < IN; i++) vec[i] = $urandom_range(0, 255) - 128;
        send_vector(1);
        wait_done(base + 2);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
